// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: widths, reset PC default and the
// fetch sequencer state encoding.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_RST,
        ST_REQ,
        ST_WAIT,
        ST_EXEC,
        ST_TRAP
    } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: jalr > jal > taken branch > sequential.
// Ports:
//   pc, imm, alu_result             : operands
//   is_jalr, is_jal, is_branch      : control class of held instruction
//   exe_branch                      : ALU branch-taken verdict
//   misaligned (PC_MISALIGN_TRAP_EN): target has nonzero [1:0]
//   next_pc                         : selected target; without the trap
//                                     build its low two bits are cleared
module pc_next_sel
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    input  logic            is_jalr,
    input  logic            is_jal,
    input  logic            is_branch,
    input  logic            exe_branch,
`ifdef PC_MISALIGN_TRAP_EN
    output logic            misaligned,
`endif
    output logic [XLEN-1:0] next_pc
);

    logic [XLEN-1:0] target;

    // Several class bits may be set together; the if-chain order is the
    // priority, so no error is raised for overlapping classes.
    always_comb begin
        target = pc + 32'd4;
        if (is_jalr) begin
            target = alu_result & ~32'h1;
        end else if (is_jal) begin
            target = pc + imm;
        end else if (is_branch && exe_branch) begin
            target = pc + imm;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    assign misaligned = |target[1:0];
    assign next_pc    = target;
`else
    assign next_pc    = target & ~32'h3;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// PC holder and instruction-fetch sequencer (RST/REQ/WAIT/EXEC[/TRAP]).
// Ports:
//   clk, reset (sync, active-high)
//   imem_req_valid/ready/addr : fetch request handshake
//   imem_rsp_valid/data       : fetch response (honoured only in WAIT)
//   instr, instr_valid, pc, pc_plus4 : held instruction for the datapath
//   is_branch/is_jal/is_jalr, exe_branch, imm, alu_result, retire
//   trap, trap_pc             : sticky misaligned-target trap
// Build option PC_MISALIGN_TRAP_EN: misaligned next PC traps instead of
// having its low two bits cleared; trap/trap_pc are tied 0 otherwise.
module pc_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic [ILEN-1:0] instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            exe_branch,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    input  logic            retire,
    output logic            trap,
    output logic [XLEN-1:0] trap_pc
);

    fetch_state_t    state;
    fetch_state_t    state_nx;
    logic [XLEN-1:0] pc_q;
    logic [ILEN-1:0] instr_q;
    logic [XLEN-1:0] next_pc;
    logic            take;
    logic            bad;

    pc_next_sel u_sel (
        .pc         (pc_q),
        .imm        (imm),
        .alu_result (alu_result),
        .is_jalr    (is_jalr),
        .is_jal     (is_jal),
        .is_branch  (is_branch),
        .exe_branch (exe_branch),
`ifdef PC_MISALIGN_TRAP_EN
        .misaligned (bad),
`endif
        .next_pc    (next_pc)
    );

`ifndef PC_MISALIGN_TRAP_EN
    assign bad = 1'b0;
`endif

    assign take = (state == ST_EXEC) && retire;

    always_comb begin
        state_nx       = state;
        imem_req_valid = 1'b0;
        imem_req_addr  = pc_q;
        instr_valid    = 1'b0;
        unique case (state)
            ST_RST: begin
                imem_req_addr = '0;
                state_nx      = ST_REQ;
            end
            ST_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rsp_valid) state_nx = ST_EXEC;
            end
            ST_EXEC: begin
                instr_valid = 1'b1;
                if (retire) state_nx = bad ? ST_TRAP : ST_REQ;
            end
`ifdef PC_MISALIGN_TRAP_EN
            ST_TRAP: begin
                state_nx = ST_TRAP;
            end
`endif
            default: begin
                state_nx = ST_RST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_RST;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_WAIT && imem_rsp_valid) instr_q <= imem_rsp_data;
            if (take && !bad) pc_q <= next_pc;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic            trap_q;
    logic [XLEN-1:0] trap_pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            trap_q    <= 1'b0;
            trap_pc_q <= '0;
        end else if (take && bad) begin
            trap_q    <= 1'b1;
            trap_pc_q <= next_pc;
        end
    end

    assign trap    = trap_q;
    assign trap_pc = trap_pc_q;
`else
    assign trap    = 1'b0;
    assign trap_pc = '0;
`endif

    assign instr    = instr_q;
    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: driver pushes expected fetch
// addresses and instruction words, a negedge monitor pops and compares.
module tb_pc_fetch_unit;

    localparam logic [31:0] RP = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        is_branch = 1'b0;
    logic        is_jal = 1'b0;
    logic        is_jalr = 1'b0;
    logic        exe_branch = 1'b0;
    logic [31:0] imm = '0;
    logic [31:0] alu_result = '0;
    logic        retire = 1'b0;
    logic        trap;
    logic [31:0] trap_pc;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(RP)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .is_branch      (is_branch),
        .is_jal         (is_jal),
        .is_jalr        (is_jalr),
        .exe_branch     (exe_branch),
        .imm            (imm),
        .alu_result     (alu_result),
        .retire         (retire),
        .trap           (trap),
        .trap_pc        (trap_pc)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_instr[$];
    int          acc_cyc[$];
    logic [31:0] exec_pc = '0;
    logic [31:0] last_instr = '0;
    logic [31:0] m_pc = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares whatever the DUT presents against the queues.
    always @(negedge clk) begin
        if (reset) begin
            last_instr = '0;
        end else begin
            if (imem_req_valid) begin
                if (exp_addr.size() == 0) begin
                    n_chk++;
                    $display("FAIL req_unexpected: got addr %h expected no request",
                             imem_req_addr);
                end else begin
                    chk("req_addr", imem_req_addr, exp_addr[0]);
                    chk("req_no_ivalid", {31'b0, instr_valid}, 32'd0);
                    if (imem_req_ready) begin
                        exec_pc = exp_addr.pop_front();
                        acc_cyc.push_back(cyc);
                    end
                end
            end
            if (instr_valid) begin
                if (exp_instr.size() == 0) begin
                    n_chk++;
                    $display("FAIL instr_unexpected: got %h expected none", instr);
                end else begin
                    chk("instr", instr, exp_instr[0]);
                    chk("exec_pc", pc, exec_pc);
                    chk("pc_plus4", pc_plus4, exec_pc + 32'd4);
                    if (retire) last_instr = exp_instr.pop_front();
                end
            end else begin
                chk("instr_hold", instr, last_instr);
            end
        end
    end

    task automatic clear_ctrl();
        is_jalr    = 1'b0;
        is_jal     = 1'b0;
        is_branch  = 1'b0;
        exe_branch = 1'b0;
        imm        = '0;
        alu_result = '0;
        retire     = 1'b0;
    endtask

    // Caller may leave imem_rsp_valid high to model a response racing reset.
    task automatic do_reset();
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        clear_ctrl();
        tick();
        imem_rsp_valid = 1'b0;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'd0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", pc, RP);
        chk("rst_pc_plus4", pc_plus4, RP + 32'd4);
        chk("rst_trap", {31'b0, trap}, 32'd0);
        chk("rst_trap_pc", trap_pc, 32'd0);
        reset = 1'b0;
        exp_addr.delete();
        exp_instr.delete();
        acc_cyc.delete();
        m_pc = RP;
        exp_addr.push_back(RP);
        tick();
        chk("first_req", {31'b0, imem_req_valid}, 32'd1);
    endtask

    task automatic do_instr(input int stall, input int rdly, input int rtdly,
                            input bit jr, input bit j, input bit b,
                            input bit eb, input logic [31:0] im,
                            input logic [31:0] alu, output bit trapped);
        logic [31:0] d;
        logic [31:0] t;
        int          n;
        trapped = 1'b0;
        n = 0;
        while (!imem_req_valid && n < 20) begin
            tick();
            n++;
        end
        n_chk++;
        if (imem_req_valid) begin
            n_pass++;
        end else begin
            $display("FAIL req_timeout: got no request expected one within 20 cycles");
            return;
        end
        repeat (stall) begin
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'($urandom % 2);
            imem_rsp_data  = $urandom;
            tick();
        end
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        tick();
        imem_req_ready = 1'b0;
        repeat (rdly) tick();
        d = $urandom;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = d;
        exp_instr.push_back(d);
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        is_jalr    = jr;
        is_jal     = j;
        is_branch  = b;
        exe_branch = eb;
        imm        = im;
        alu_result = alu;
        repeat (rtdly) begin
            imem_rsp_valid = 1'($urandom % 2);
            tick();
        end
        imem_rsp_valid = 1'b0;
        retire = 1'b1;
        if (jr) t = {alu[31:1], 1'b0};
        else if (j) t = m_pc + im;
        else if (b && eb) t = m_pc + im;
        else t = m_pc + 32'd4;
`ifdef PC_MISALIGN_TRAP_EN
        if (t[1:0] != 2'b00) begin
            trapped = 1'b1;
        end else begin
            m_pc = t;
            exp_addr.push_back(t);
        end
`else
        m_pc = {t[31:2], 2'b00};
        exp_addr.push_back(m_pc);
`endif
        tick();
        clear_ctrl();
        if (trapped) begin
            chk("trap", {31'b0, trap}, 32'd1);
            chk("trap_pc", trap_pc, t);
            chk("trap_pc_hold", pc, m_pc);
            repeat (4) tick();
            chk("trap_no_req", {31'b0, imem_req_valid}, 32'd0);
        end else begin
            chk("no_trap", {31'b0, trap}, 32'd0);
        end
    endtask

    initial begin
        bit          tr;
        logic [31:0] r;
        logic [31:0] im;
        logic [31:0] alu;

        do_reset();

        // Back-to-back sequential fetches with zero wait states.
        for (int i = 0; i < 3; i++) do_instr(0, 0, 0, 0, 0, 0, 0, '0, '0, tr);
        if (acc_cyc.size() >= 3) begin
            chk("spacing_a", acc_cyc[1] - acc_cyc[0], 32'd3);
            chk("spacing_b", acc_cyc[2] - acc_cyc[1], 32'd3);
        end else begin
            n_chk++;
            $display("FAIL spacing: got %0d accepts expected 3", acc_cyc.size());
        end

        // Four cycles of backpressure on the first request.
        do_reset();
        do_instr(4, 0, 0, 0, 0, 0, 0, '0, '0, tr);

        // Branch taken/not taken at 0x200, JALR to 0x301 -> 0x300.
        do_instr(0, 0, 0, 1, 0, 0, 0, '0, 32'h200, tr);
        do_instr(0, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFF8, '0, tr);
        chk("br_taken_pc", m_pc, 32'h1F8);
        do_instr(0, 1, 1, 1, 0, 0, 0, '0, 32'h200, tr);
        do_instr(0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFF8, '0, tr);
        do_instr(0, 0, 0, 1, 0, 0, 0, '0, 32'h301, tr);

        // JAL to a misaligned target from 0x400.
        do_instr(0, 0, 0, 1, 0, 0, 0, '0, 32'h400, tr);
        do_instr(0, 0, 0, 0, 1, 0, 0, 32'd6, '0, tr);
        if (tr) do_reset();

        // Wrap-around at 2^32.
        do_instr(0, 0, 0, 1, 0, 0, 0, '0, 32'hFFFF_FFFC, tr);
        do_instr(0, 0, 0, 0, 0, 0, 0, '0, '0, tr);

        // Reset while a response arrives in WAIT.
        do_instr(0, 0, 0, 0, 0, 0, 0, '0, '0, tr);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        do_reset();

        // Randomised traffic.
        for (int i = 0; i < 150; i++) begin
            r  = $urandom;
            im = {{20{r[11]}}, r[11:0]};
            if ($urandom % 4 != 0) im[1:0] = 2'b00;
            alu = $urandom;
            if ($urandom % 4 != 0) alu[1] = 1'b0;
            do_instr($urandom_range(0, 3), $urandom_range(0, 2),
                     $urandom_range(0, 2), ($urandom % 6) == 0,
                     ($urandom % 6) == 0, ($urandom % 3) == 0,
                     1'($urandom % 2), im, alu, tr);
            if (tr) do_reset();
        end

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
